// File: rtl/i2c_pkg.sv
// Shared definitions for the write-only I2C master: state codes, default
// clock rates and the SCL level helper for the four-phase bit states.
package i2c_pkg;

    localparam int unsigned CLK_HZ_DEF = 100_000_000;
    localparam int unsigned I2C_HZ_DEF = 100_000;
    localparam int unsigned ST_W       = 5;

    typedef enum logic [ST_W-1:0] {
        IDLE      = 5'd0,
        START_0   = 5'd1,
        START_1   = 5'd2,
        ADDR_0    = 5'd3,
        ADDR_1    = 5'd4,
        ADDR_2    = 5'd5,
        ADDR_3    = 5'd6,
        RD_ACK1_0 = 5'd7,
        RD_ACK1_1 = 5'd8,
        RD_ACK1_2 = 5'd9,
        RD_ACK1_3 = 5'd10,
        DATA_0    = 5'd11,
        DATA_1    = 5'd12,
        DATA_2    = 5'd13,
        DATA_3    = 5'd14,
        RD_ACK2_0 = 5'd15,
        RD_ACK2_1 = 5'd16,
        RD_ACK2_2 = 5'd17,
        RD_ACK2_3 = 5'd18,
        STOP_0    = 5'd19,
        STOP_1    = 5'd20,
        STOP_2    = 5'd21
    } state_t;

    // Bit states start at code 3, so (code + 1) mod 4 is the phase; SCL is high in phases 1 and 2.
    function automatic logic bit_phase_scl(input state_t s);
        logic [ST_W-1:0] p;
        p = s;
        p = p + 5'd1;
        return (p[1:0] == 2'd1) || (p[1:0] == 2'd2);
    endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// Free-running divider that emits a one-clock pulse every QTR clocks,
// pacing each quarter of an SCL period.
module i2c_qtr_tick #(
    parameter int unsigned QTR = 250
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned   CW   = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] LAST = CW'(QTR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/i2c_core.sv
// Write-only I2C master: START, address+W, ACK, one data byte, ACK, STOP.
// All pin-facing outputs are registered copies decoded from next_state.
module i2c_core
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF,
    parameter int unsigned I2C_HZ = I2C_HZ_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i2c_addr_i,
    input  logic [7:0] i2c_data_i,
    input  logic       i2c_start_i,
    output logic       i2c_ready_o,
    output logic       SCL,
    inout  wire        SDA
);

    localparam int unsigned QTR = CLK_HZ / (4 * I2C_HZ);

    state_t     state;
    state_t     next_state;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       nack_q, nack_d;
    logic       scl_q, scl_d;
    logic       sda_oe_q, sda_oe_d;
    logic       ready_q, ready_d;
    logic       tick;
    wire        sda_pad_i;

    assign sda_pad_i   = SDA;
    assign SDA         = sda_oe_q ? 1'b0 : 1'bz;
    assign SCL         = scl_q;
    assign i2c_ready_o = ready_q;

    i2c_qtr_tick #(.QTR(QTR)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    always_comb begin
        next_state = state;
        shift_d    = shift_q;
        data_d     = data_q;
        bit_cnt_d  = bit_cnt_q;
        nack_d     = nack_q;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (i2c_start_i) begin
                        shift_d    = {i2c_addr_i, 1'b0};
                        data_d     = i2c_data_i;
                        bit_cnt_d  = 3'd0;
                        next_state = START_0;
                    end else begin
                        next_state = IDLE;
                    end
                end
                ADDR_3, DATA_3: begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q != 3'd7) begin
                        next_state = (state == ADDR_3) ? ADDR_0 : DATA_0;
                    end else begin
                        next_state = (state == ADDR_3) ? RD_ACK1_0 : RD_ACK2_0;
                    end
                end
                RD_ACK1_2, RD_ACK2_2: begin
                    nack_d     = sda_pad_i;
                    next_state = state_t'(state + 5'd1);
                end
                RD_ACK1_3: begin
                    if (nack_q) begin
                        next_state = STOP_0;
                    end else begin
                        shift_d    = data_q;
                        bit_cnt_d  = 3'd0;
                        next_state = DATA_0;
                    end
                end
                RD_ACK2_3: next_state = STOP_0;
                STOP_2:    next_state = IDLE;
                START_0, START_1, ADDR_0, ADDR_1, ADDR_2, RD_ACK1_0, RD_ACK1_1,
                DATA_0, DATA_1, DATA_2, RD_ACK2_0, RD_ACK2_1, STOP_0, STOP_1:
                    next_state = state_t'(state + 5'd1);
                default:   next_state = IDLE;
            endcase
        end else begin
            next_state = state;
        end
    end

    // Decode pin levels for the state being entered so they register alongside it.
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        ready_d  = 1'b0;
        case (next_state)
            IDLE:    ready_d = 1'b1;
            START_0: sda_oe_d = 1'b0;
            START_1: sda_oe_d = 1'b1;
            ADDR_0, ADDR_1, ADDR_2, ADDR_3, DATA_0, DATA_1, DATA_2, DATA_3: begin
                scl_d    = bit_phase_scl(next_state);
                sda_oe_d = ~shift_d[7];
            end
            RD_ACK1_0, RD_ACK1_1, RD_ACK1_2, RD_ACK1_3,
            RD_ACK2_0, RD_ACK2_1, RD_ACK2_2, RD_ACK2_3:
                scl_d = bit_phase_scl(next_state);
            STOP_0: begin
                scl_d    = 1'b0;
                sda_oe_d = 1'b1;
            end
            STOP_1:  sda_oe_d = 1'b1;
            STOP_2:  sda_oe_d = 1'b0;
            default: ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            bit_cnt_q <= 3'd0;
            nack_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state     <= next_state;
            shift_q   <= shift_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            nack_q    <= nack_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
            ready_q   <= ready_d;
        end
    end

endmodule

// File: tb/tb_i2c_core.sv
// Self-checking bench for i2c_core: table of frames decoded from the bus,
// plus hand sequences for mid-frame reset and back-to-back starts.
module tb_i2c_core;

    localparam int QTR = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] addr = 7'h00;
    logic [7:0] data = 8'h00;
    logic       start = 1'b0;
    logic       ready;
    logic       scl;
    wire        SDA;
    logic       nack1_r = 1'b0;
    logic       slave_drv;
    logic [4:0] st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_core #(.CLK_HZ(4_000_000), .I2C_HZ(100_000)) dut (
        .clk         (clk),
        .rst         (rst),
        .i2c_addr_i  (addr),
        .i2c_data_i  (data),
        .i2c_start_i (start),
        .i2c_ready_o (ready),
        .SCL         (scl),
        .SDA         (SDA)
    );

    pullup (SDA);
    assign st  = dut.state;
    assign SDA = slave_drv ? 1'b0 : 1'bz;

    always_comb begin
        slave_drv = 1'b0;
        if (st >= 5'd7 && st <= 5'd10) slave_drv = !nack1_r;
        else if (st >= 5'd15 && st <= 5'd18) slave_drv = 1'b1;
        else slave_drv = 1'b0;
    end

    // Bus monitor: bits at SCL rises, START/STOP events, SCL period and DATA-state occupancy.
    logic     rise_bit [1024];
    int       rise_n = 0, start_n = 0, stop_n = 0, per_bad = 0, data_n = 0;
    int       cyc = 0, last_rise = 0;
    logic     prev_scl = 1'b1, prev_sda = 1'b1, have_prev = 1'b0;

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_scl <= scl;
        prev_sda <= SDA;
        if (!prev_scl && scl) begin
            rise_bit[rise_n[9:0]] <= SDA;
            rise_n    <= rise_n + 1;
            last_rise <= cyc;
            if (!ready && have_prev && (cyc - last_rise) != 4 * QTR) per_bad <= per_bad + 1;
        end
        if (ready) have_prev <= 1'b0;
        else if (!prev_scl && scl) have_prev <= 1'b1;
        if (prev_scl && scl && prev_sda && !SDA) start_n <= start_n + 1;
        if (prev_scl && scl && !prev_sda && SDA) stop_n <= stop_n + 1;
        if (st >= 5'd11 && st <= 5'd18) data_n <= data_n + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input logic lvl, input int budget, output int n);
        n = 0;
        while (ready !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        bit         nack;
        bit         chg;
        logic [7:0] exp_ab;
        logic [7:0] exp_db;
        int         exp_rises;
        int         exp_ticks;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int r0, s0, p0, pb0, d0, lat, len, t, g;
        logic [7:0] ab, db;

        vecs[0] = '{7'h72, 8'h45, 1'b0, 1'b0, 8'hE4, 8'h45, 19, 77};
        vecs[1] = '{7'h41, 8'h92, 1'b0, 1'b0, 8'h82, 8'h92, 19, 77};
        vecs[2] = '{7'h7F, 8'h00, 1'b1, 1'b0, 8'hFE, 8'h00, 10, 41};
        vecs[3] = '{7'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 8'hFF, 19, 77};
        vecs[4] = '{7'h72, 8'h45, 1'b0, 1'b1, 8'hE4, 8'h45, 19, 77};

        repeat (3) @(negedge clk);
        check("rst_state", int'(st), 0);
        check("rst_scl", int'(scl), 1);
        check("rst_sda", int'(SDA), 1);
        check("rst_oe", int'(dut.sda_oe_q), 0);
        check("rst_ready", int'(ready), 1);
        rst = 1'b0;
        repeat (2 * QTR) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            addr    = vecs[i].addr;
            data    = vecs[i].data;
            nack1_r = vecs[i].nack;
            repeat (QTR) @(negedge clk);
            r0 = rise_n; s0 = start_n; p0 = stop_n; pb0 = per_bad; d0 = data_n;
            start = 1'b1;
            wait_ready(1'b0, 3 * QTR, lat);
            check($sformatf("v%0d_ready_fall_lat_%0d", i, lat), int'(lat >= 1 && lat <= QTR), 1);
            start = 1'b0;
            if (vecs[i].chg) begin
                addr = 7'h0D;
                data = 8'hBA;
            end
            wait_ready(1'b1, 100 * QTR, len);
            check($sformatf("v%0d_frame_clks", i), len, vecs[i].exp_ticks * QTR);
            repeat (2 * QTR) @(negedge clk);
            check($sformatf("v%0d_rises", i), rise_n - r0, vecs[i].exp_rises);
            ab = 8'h00;
            for (int k = 0; k < 8; k++) ab = {ab[6:0], rise_bit[r0 + k]};
            check($sformatf("v%0d_addr_byte", i), int'(ab), int'(vecs[i].exp_ab));
            check($sformatf("v%0d_ack1_bit", i), int'(rise_bit[r0 + 8]), int'(vecs[i].nack));
            if (!vecs[i].nack) begin
                db = 8'h00;
                for (int k = 9; k < 17; k++) db = {db[6:0], rise_bit[r0 + k]};
                check($sformatf("v%0d_data_byte", i), int'(db), int'(vecs[i].exp_db));
                check($sformatf("v%0d_ack2_bit", i), int'(rise_bit[r0 + 17]), 0);
                check($sformatf("v%0d_stop_rise_sda", i), int'(rise_bit[r0 + 18]), 0);
                check($sformatf("v%0d_data_clks", i), data_n - d0, 36 * QTR);
            end else begin
                check($sformatf("v%0d_stop_rise_sda", i), int'(rise_bit[r0 + 9]), 0);
                check($sformatf("v%0d_data_clks", i), data_n - d0, 0);
            end
            check($sformatf("v%0d_starts", i), start_n - s0, 1);
            check($sformatf("v%0d_stops", i), stop_n - p0, 1);
            check($sformatf("v%0d_scl_period_bad", i), per_bad - pb0, 0);
            check($sformatf("v%0d_ready_after", i), int'(ready), 1);
        end
        nack1_r = 1'b0;

        // Reset asserted in DATA_1 must release the bus without waiting for a clock edge.
        addr  = 7'h72;
        data  = 8'h45;
        start = 1'b1;
        wait_ready(1'b0, 3 * QTR, lat);
        start = 1'b0;
        t = 0;
        while (st != 5'd12 && t < 100 * QTR) begin
            @(negedge clk);
            t++;
        end
        check("reach_data_1", int'(st), 12);
        #1 rst = 1'b1;
        #1;
        check("midrst_state", int'(st), 0);
        check("midrst_scl", int'(scl), 1);
        check("midrst_sda", int'(SDA), 1);
        check("midrst_oe", int'(dut.sda_oe_q), 0);
        check("midrst_ready", int'(ready), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * QTR) @(negedge clk);

        // Start held high across a frame: the next frame begins after one IDLE tick.
        start = 1'b1;
        wait_ready(1'b0, 3 * QTR, lat);
        wait_ready(1'b1, 100 * QTR, len);
        check("b2b_first_len", len, 77 * QTR);
        g = 0;
        while (ready && g < 3 * QTR) begin
            @(negedge clk);
            g++;
        end
        check("b2b_idle_gap", g, QTR);
        start = 1'b0;
        wait_ready(1'b1, 100 * QTR, len);
        check("b2b_second_len", len, 77 * QTR);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
